// File: rtl/ws2812b_multi_driver_pkg.sv
// Shared definitions for the WS2812B multi-channel driver: register map,
// CTRL bit positions, FSM state types and pulse-timing derivation.
package ws2812b_multi_driver_pkg;

    localparam logic [3:0] ADDR_CTRL = 4'h0;
    localparam logic [3:0] ADDR_R    = 4'h1;
    localparam logic [3:0] ADDR_G    = 4'h2;
    localparam logic [3:0] ADDR_B    = 4'h3;
    localparam logic [3:0] ADDR_LEN  = 4'h4;
    localparam logic [3:0] ADDR_MASK = 4'h5;
    localparam logic [3:0] ADDR_DR   = 4'h6;
    localparam logic [3:0] ADDR_DG   = 4'h7;
    localparam logic [3:0] ADDR_DB   = 4'h8;

    localparam int CTRL_LATCH = 7;
    localparam int CTRL_CLEAR = 6;
    localparam int CTRL_GRAD  = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_LATCH} drv_state_t;
    typedef enum logic [1:0] {ENC_IDLE, ENC_BIT, ENC_LATCH} enc_state_t;

    // 1.25 us bit period, 0.4 us / 0.8 us high times, expressed in clocks
    function automatic int tbit_cycles(input int mhz);
        return mhz * 5 / 4;
    endfunction

    function automatic int t0h_cycles(input int mhz);
        return mhz * 2 / 5;
    endfunction

    function automatic int t1h_cycles(input int mhz);
        return mhz * 4 / 5;
    endfunction

    function automatic int latch_cycles(input int mhz, input int us);
        return us * mhz;
    endfunction

endpackage

// File: rtl/ws2812b_multi_driver_bit_encoder.sv
// Serialises one 24-bit pixel MSB first, or holds the line low for the latch
// period; ready doubles as "accept next item" so pixels chain with no gap.
module ws2812b_bit_encoder
    import ws2812b_multi_driver_pkg::*;
#(
    parameter int CLOCK_MHZ = 64,
    parameter int LATCH_US  = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel,
    input  logic        valid,
    input  logic        latch_req,
    output logic        ready,
    output logic        line
);

    localparam int TBIT      = tbit_cycles(CLOCK_MHZ);
    localparam int T0H       = t0h_cycles(CLOCK_MHZ);
    localparam int T1H       = t1h_cycles(CLOCK_MHZ);
    localparam int LATCH_CYC = latch_cycles(CLOCK_MHZ, LATCH_US);
    localparam int CNT_W     = $clog2(LATCH_CYC + 1);

    localparam logic [CNT_W-1:0] TBIT_LAST  = CNT_W'(TBIT - 1);
    localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);

    enc_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_idx;
    logic [23:0]      shift;
    logic             bit_last, latch_last, take_pix, take_latch;

    always_comb begin
        bit_last   = (state == ENC_BIT) && (cnt == TBIT_LAST) && (bit_idx == 5'd0);
        latch_last = (state == ENC_LATCH) && (cnt == LATCH_LAST);
        ready      = (state == ENC_IDLE) || bit_last || latch_last;
        take_pix   = ready && valid;
        take_latch = ready && !valid && latch_req;
        state_next = state;
        if (take_pix)
            state_next = ENC_BIT;
        else if (take_latch)
            state_next = ENC_LATCH;
        else if (ready)
            state_next = ENC_IDLE;
        line = (state == ENC_BIT) && (cnt < (shift[23] ? T1H_C : T0H_C));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ENC_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state <= state_next;
            if (take_pix) begin
                shift   <= pixel;
                bit_idx <= 5'd23;
                cnt     <= '0;
            end else if (take_latch) begin
                cnt <= '0;
            end else if (state == ENC_BIT) begin
                if (cnt == TBIT_LAST) begin
                    cnt     <= '0;
                    bit_idx <= bit_idx - 5'd1;
                    shift   <= {shift[22:0], 1'b0};
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == ENC_LATCH) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812b_multi_driver.sv
// TinyQV peripheral driving up to NUM_CHANNELS WS2812B strips from one encoder:
// register file, LED counter, gradient accumulator, mask fan-out and frame FSM.
module ws2812b_multi_driver
    import ws2812b_multi_driver_pkg::*;
#(
    parameter int CLOCK_MHZ    = 64,
    parameter int NUM_CHANNELS = 4,
    parameter int LEN_W        = 8,
    parameter int LATCH_US     = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    drv_state_t              state, state_next;
    logic [7:0]              reg_r, reg_g, reg_b, reg_dr, reg_dg, reg_db;
    logic [LEN_W-1:0]        reg_len, led_cnt;
    logic [NUM_CHANNELS-1:0] reg_mask, mask_q;
    logic [7:0]              work_r, work_g, work_b;
    logic                    latch_q, clear_q, grad_q;
    logic                    ready_int, wr_en, start;
    logic                    valid, latch_req, enc_ready, enc_line;
    logic [23:0]             pixel;
    logic                    unused_inputs;

    assign unused_inputs = ^ui_in;
    assign ready_int     = (state == ST_IDLE);
    assign wr_en         = data_write && ready_int;
    // A CTRL write with nothing to send and no latch leaves the block idle
    assign start = wr_en && (address == ADDR_CTRL) &&
                   ((reg_len != '0) || data_in[CTRL_LATCH]);
    assign pixel = clear_q ? 24'h0 : {work_g, work_r, work_b};

    always_comb begin
        state_next = state;
        valid      = 1'b0;
        latch_req  = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD, ST_SEND: begin
                valid     = (led_cnt != '0);
                latch_req = (led_cnt == '0) && latch_q;
                if (enc_ready) begin
                    if (led_cnt != '0)
                        state_next = ST_SEND;
                    else if (latch_q)
                        state_next = ST_LATCH;
                    else
                        state_next = ST_IDLE;
                end
            end
            ST_LATCH: if (enc_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_r    <= 8'h20;
            reg_g    <= '0;
            reg_b    <= '0;
            reg_dr   <= '0;
            reg_dg   <= '0;
            reg_db   <= '0;
            reg_len  <= '0;
            reg_mask <= NUM_CHANNELS'(1);
            work_r   <= '0;
            work_g   <= '0;
            work_b   <= '0;
            led_cnt  <= '0;
            mask_q   <= '0;
            latch_q  <= 1'b0;
            clear_q  <= 1'b0;
            grad_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_R:    reg_r    <= data_in;
                    ADDR_G:    reg_g    <= data_in;
                    ADDR_B:    reg_b    <= data_in;
                    ADDR_LEN:  reg_len  <= LEN_W'(data_in);
                    ADDR_MASK: reg_mask <= data_in[NUM_CHANNELS-1:0];
                    ADDR_DR:   reg_dr   <= data_in;
                    ADDR_DG:   reg_dg   <= data_in;
                    ADDR_DB:   reg_db   <= data_in;
                    default:   ;
                endcase
            end
            if (start) begin
                work_r  <= reg_r;
                work_g  <= reg_g;
                work_b  <= reg_b;
                led_cnt <= reg_len;
                mask_q  <= reg_mask;
                latch_q <= data_in[CTRL_LATCH];
                clear_q <= data_in[CTRL_CLEAR];
                grad_q  <= data_in[CTRL_GRAD];
            end else if (valid && enc_ready) begin
                // Step lands as the pixel is taken, so the next LED sees it
                led_cnt <= led_cnt - 1'b1;
                if (grad_q) begin
                    work_r <= work_r + reg_dr;
                    work_g <= work_g + reg_dg;
                    work_b <= work_b + reg_db;
                end
            end
        end
    end

    ws2812b_bit_encoder #(
        .CLOCK_MHZ(CLOCK_MHZ),
        .LATCH_US (LATCH_US)
    ) u_encoder (
        .clk      (clk),
        .rst      (rst),
        .pixel    (pixel),
        .valid    (valid),
        .latch_req(latch_req),
        .ready    (enc_ready),
        .line     (enc_line)
    );

    always_comb begin
        uo_out = '0;
        uo_out[1 +: NUM_CHANNELS] = mask_q & {NUM_CHANNELS{enc_line}};
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL: data_out = {6'b0, ~ready_int, ready_int};
            ADDR_R:    data_out = reg_r;
            ADDR_G:    data_out = reg_g;
            ADDR_B:    data_out = reg_b;
            ADDR_LEN:  data_out = 8'(reg_len);
            ADDR_MASK: data_out = 8'(reg_mask);
            ADDR_DR:   data_out = reg_dr;
            ADDR_DG:   data_out = reg_dg;
            ADDR_DB:   data_out = reg_db;
            default:   data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_ws2812b_multi_driver.sv
// Self-checking bench: register vectors, directed frames and random frames,
// each strip waveform compared against a per-cycle model built from the timing rules.
module tb_ws2812b_multi_driver;

    localparam int TBIT      = 80;
    localparam int T0H       = 25;
    localparam int T1H       = 51;
    localparam int LATCH_CYC = 5120;
    localparam int LED_CYC   = 24 * TBIT;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in, uo_out, data_in, data_out;
    logic [3:0] address;
    logic       data_write;

    int errors = 0;
    int checks = 0;
    logic [7:0] cap[$];

    logic [7:0] m_r, m_g, m_b, m_dr, m_dg, m_db, m_len;
    logic [3:0] m_mask;

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    ws2812b_multi_driver dut (
        .clk       (clk),
        .rst       (rst),
        .ui_in     (ui_in),
        .uo_out    (uo_out),
        .address   (address),
        .data_write(data_write),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reset_model();
        m_r = 8'h20; m_g = 0; m_b = 0; m_dr = 0; m_dg = 0; m_db = 0;
        m_len = 0; m_mask = 4'h1;
    endtask

    // One register write; leaves the bench at the negedge after the capturing edge
    task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        case (a)
            4'h1: m_r = d;
            4'h2: m_g = d;
            4'h3: m_b = d;
            4'h4: m_len = d;
            4'h5: m_mask = d[3:0];
            4'h6: m_dr = d;
            4'h7: m_dg = d;
            4'h8: m_db = d;
            default: ;
        endcase
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk);
        address = a;
        #1 v = data_out;
    endtask

    function automatic logic [23:0] model_pixel(input int k, input logic [7:0] ctrl);
        logic [7:0] r, g, b;
        if (ctrl[6]) return 24'h0;
        r = m_r; g = m_g; b = m_b;
        if (ctrl[5]) begin
            r = 8'(int'(m_r) + k * int'(m_dr));
            g = 8'(int'(m_g) + k * int'(m_dg));
            b = 8'(int'(m_b) + k * int'(m_db));
        end
        return {g, r, b};
    endfunction

    function automatic logic model_level(input int t, input logic [7:0] ctrl, input int len);
        int led, bitn, ph;
        logic [23:0] px;
        if (t >= len * LED_CYC) return 1'b0;
        led  = t / LED_CYC;
        bitn = (t % LED_CYC) / TBIT;
        ph   = t % TBIT;
        px   = model_pixel(led, ctrl);
        return ph < (px[23 - bitn] ? T1H : T0H);
    endfunction

    function automatic int ones_in_bit(input int bit_no, input int ch);
        int n = 0;
        for (int t = bit_no * TBIT; t < (bit_no + 1) * TBIT && t < cap.size(); t++)
            if (cap[t][ch + 1]) n++;
        return n;
    endfunction

    function automatic logic [7:0] decode_byte(input int led, input int ofs, input int ch);
        logic [7:0] v = 0;
        for (int j = 0; j < 8; j++)
            v[7 - j] = ones_in_bit(led * 24 + ofs + j, ch) > (T0H + T1H) / 2;
        return v;
    endfunction

    // Starts a frame, captures uo_out until ready returns, compares against the model
    task automatic run_frame(input string tag, input logic [7:0] ctrl, input bit mid_writes);
        int exp_len, len, bad;
        int mism[4];
        logic [3:0] mask;
        logic lvl;
        len     = int'(m_len);
        mask    = m_mask;
        exp_len = len * LED_CYC + (ctrl[7] ? LATCH_CYC : 0);
        cap.delete();
        applyStimulus(4'h0, ctrl);
        #1;
        checkOutput({tag, " load status"}, data_out, 8'h02);
        checkOutput({tag, " load lines"}, uo_out, 8'h00);
        for (int guard = 0; guard < exp_len + 200; guard++) begin
            @(negedge clk);
            address = 4'h0; data_write = 1'b0;
            #1;
            if (data_out[0]) break;
            cap.push_back(uo_out);
            if (mid_writes && cap.size() == 100) begin
                address = 4'h1; data_in = 8'h55; data_write = 1'b1;
            end
            if (mid_writes && cap.size() == 200) begin
                address = 4'h0; data_in = 8'h00; data_write = 1'b1;
            end
        end
        checkOutput({tag, " length"}, cap.size(), exp_len);
        bad = 0;
        for (int ch = 0; ch < 4; ch++) mism[ch] = 0;
        for (int t = 0; t < cap.size(); t++) begin
            lvl = model_level(t, ctrl, len);
            for (int ch = 0; ch < 4; ch++)
                if (cap[t][ch + 1] !== (mask[ch] & lvl)) mism[ch]++;
            if (cap[t][0] !== 1'b0 || cap[t][7:5] !== 3'b000) bad++;
        end
        for (int ch = 0; ch < 4; ch++)
            checkOutput($sformatf("%s wave ch%0d mismatched cycles", tag, ch), mism[ch], 0);
        checkOutput({tag, " unused bits"}, bad, 0);
    endtask

    task automatic add_vec(input bit wr, input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] e, input string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] ctrl;
        logic [7:0] grad_exp[3];
        int seen, viol;

        rst = 1'b1; data_write = 1'b0; address = 4'h0; data_in = 8'h00;
        ui_in = 8'($urandom);
        reset_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("rst uo_out", uo_out, 8'h00);

        add_vec(0, 4'h0, 8'h00, 8'h01, "rst ctrl");
        add_vec(0, 4'h1, 8'h00, 8'h20, "rst r");
        add_vec(0, 4'h2, 8'h00, 8'h00, "rst g");
        add_vec(0, 4'h3, 8'h00, 8'h00, "rst b");
        add_vec(0, 4'h4, 8'h00, 8'h00, "rst len");
        add_vec(0, 4'h5, 8'h00, 8'h01, "rst mask");
        add_vec(0, 4'h6, 8'h00, 8'h00, "rst dr");
        add_vec(0, 4'h7, 8'h00, 8'h00, "rst dg");
        add_vec(0, 4'h8, 8'h00, 8'h00, "rst db");
        add_vec(0, 4'h9, 8'h00, 8'h00, "rd unmapped 9");
        add_vec(0, 4'hF, 8'h00, 8'h00, "rd unmapped F");
        add_vec(1, 4'h2, 8'h5A, 8'h5A, "wr g");
        add_vec(1, 4'h5, 8'hFF, 8'h0F, "wr mask");
        add_vec(1, 4'h9, 8'h77, 8'h00, "wr unmapped");
        add_vec(1, 4'h7, 8'hC3, 8'hC3, "wr dg");
        add_vec(1, 4'h8, 8'h81, 8'h81, "wr db");
        add_vec(1, 4'h4, 8'h03, 8'h03, "wr len");
        foreach (vecs[i]) begin
            if (vecs[i].wr) applyStimulus(vecs[i].addr, vecs[i].wdata);
            read_reg(vecs[i].addr, rd);
            checkOutput(vecs[i].name, rd, vecs[i].exp);
        end

        // Single LED G=0x80 B=0x01
        applyStimulus(4'h1, 8'h00); applyStimulus(4'h2, 8'h80); applyStimulus(4'h3, 8'h01);
        applyStimulus(4'h6, 8'h00); applyStimulus(4'h7, 8'h00); applyStimulus(4'h8, 8'h00);
        applyStimulus(4'h4, 8'h01); applyStimulus(4'h5, 8'h01);
        run_frame("one led", 8'h00, 1'b0);
        checkOutput("one led bit0 high", ones_in_bit(0, 0), T1H);
        checkOutput("one led bit1 high", ones_in_bit(1, 0), T0H);
        checkOutput("one led bit23 high", ones_in_bit(23, 0), T1H);

        // Two channels, latch
        applyStimulus(4'h5, 8'h0A); applyStimulus(4'h4, 8'h02);
        run_frame("mask latch", 8'h80, 1'b0);

        // Gradient with wrap
        applyStimulus(4'h1, 8'hF0); applyStimulus(4'h2, 8'h00); applyStimulus(4'h3, 8'h00);
        applyStimulus(4'h6, 8'h20); applyStimulus(4'h4, 8'h03); applyStimulus(4'h5, 8'h01);
        run_frame("gradient", 8'h20, 1'b0);
        grad_exp[0] = 8'hF0; grad_exp[1] = 8'h10; grad_exp[2] = 8'h30;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("gradient led%0d R", k), decode_byte(k, 8, 0), grad_exp[k]);
        read_reg(4'h1, rd);
        checkOutput("gradient base R kept", rd, 8'hF0);

        // Clear overrides gradient; mid-frame writes ignored
        applyStimulus(4'h4, 8'h04);
        run_frame("clear", 8'h60, 1'b1);
        read_reg(4'h1, rd);
        checkOutput("clear R write ignored", rd, 8'hF0);

        // Reset in the middle of a bit
        applyStimulus(4'h5, 8'h0F); applyStimulus(4'h2, 8'hFF); applyStimulus(4'h4, 8'h02);
        applyStimulus(4'h0, 8'h00);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (uo_out[1]) seen = 1;
        end
        checkOutput("midreset line active", seen, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        #1;
        checkOutput("midreset lines", uo_out, 8'h00);
        checkOutput("midreset status", data_out, 8'h01);
        read_reg(4'h1, rd);
        checkOutput("midreset r", rd, 8'h20);
        read_reg(4'h5, rd);
        checkOutput("midreset mask", rd, 8'h01);

        // LEN=0 without latch does nothing
        applyStimulus(4'h0, 8'h00);
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (data_out !== 8'h01 || uo_out !== 8'h00) viol++;
            @(negedge clk);
        end
        checkOutput("len0 no-op violations", viol, 0);

        run_frame("latch only", 8'h80, 1'b0);

        for (int n = 0; n < 3; n++) begin
            applyStimulus(4'h1, 8'($urandom)); applyStimulus(4'h2, 8'($urandom));
            applyStimulus(4'h3, 8'($urandom)); applyStimulus(4'h6, 8'($urandom));
            applyStimulus(4'h7, 8'($urandom)); applyStimulus(4'h8, 8'($urandom));
            applyStimulus(4'h5, 8'($urandom_range(1, 15)));
            applyStimulus(4'h4, 8'($urandom_range(1, 2)));
            ctrl = 8'($urandom_range(0, 7)) << 5;
            run_frame($sformatf("random%0d", n), ctrl, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
